// File: rtl/fetch_unit.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Keeps the PC, issues one word request at a time over a valid/ready
// channel, parks one early response in a skid buffer while ID is stalled,
// and follows stall/flush from the hazard unit and redirects from EX.
//
// Request handshake: imem_req_valid/imem_req_addr may change from cycle to
// cycle until the memory sees valid && ready on a rising clock edge; only
// that edge transfers the request. Responses come back in order, one per
// accepted request, and are never back-pressured.
module fetch_unit #(
   parameter int               XLEN      = 32,
   parameter logic [XLEN-1:0]  RESET_PC  = '0,
   parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             hazard_fe_enable,
   input  logic             hazard_if_id_clear,
   input  logic             pc_jump_enable,
   input  logic [XLEN-1:0]  pc_jump_addr,
   output logic             imem_req_valid,
   input  logic             imem_req_ready,
   output logic [XLEN-1:0]  imem_req_addr,
   input  logic             imem_rsp_valid,
   input  logic [31:0]      imem_rsp_data,
   output logic             id_valid,
   output logic [XLEN-1:0]  id_pc,
   output logic [31:0]      id_instr,
   output logic [XLEN-1:0]  id_pc_plus4
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_WAIT  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   localparam logic [XLEN-1:0] FOUR = XLEN'(4);

   state_t           state;
   logic [XLEN-1:0]  pc_q;
   logic [XLEN-1:0]  req_pc_q;
   logic             ibuf_valid;
   logic [XLEN-1:0]  ibuf_pc;
   logic [31:0]      ibuf_instr;

   logic [XLEN-1:0]  jump_target;
   logic             ifid_load;
   logic             rsp_in_wait;
   logic             req_fire;
   logic             redirect;
   logic             ibuf_take;
   logic             ibuf_fill;
   logic             rsp_direct;

   // Request generation and the qualifiers shared by the FSM and IF/ID.
   always_comb begin
      jump_target    = pc_jump_addr & ~XLEN'(3);
      ifid_load      = hazard_fe_enable && !hazard_if_id_clear;
      rsp_in_wait    = (state == S_WAIT) && imem_rsp_valid;
      // Second term: issue the next word in the same cycle the current
      // response is consumed, giving one instruction per cycle.
      imem_req_valid = ((state == S_FETCH) && !ibuf_valid) ||
                       (rsp_in_wait && ifid_load && !ibuf_valid && !pc_jump_enable);
      imem_req_addr  = pc_jump_enable ? jump_target : pc_q;
      req_fire       = imem_req_valid && imem_req_ready;
      redirect       = pc_jump_enable && (state != S_IDLE);
      ibuf_take      = ifid_load && ibuf_valid;
      ibuf_fill      = rsp_in_wait && !pc_jump_enable && !ifid_load;
      rsp_direct     = rsp_in_wait && !pc_jump_enable && !ibuf_valid;
   end

   // Fetch FSM: PC, outstanding-request tracking and skid buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         pc_q       <= RESET_PC;
         req_pc_q   <= '0;
         ibuf_valid <= 1'b0;
         ibuf_pc    <= '0;
         ibuf_instr <= NOP_INSTR;
      end else begin
         if (req_fire) begin
            req_pc_q <= imem_req_addr;
            pc_q     <= imem_req_addr + FOUR;
         end else if (redirect) begin
            pc_q <= jump_target;
         end

         if (redirect || ibuf_take) begin
            ibuf_valid <= 1'b0;
         end else if (ibuf_fill) begin
            ibuf_valid <= 1'b1;
            ibuf_pc    <= req_pc_q;
            ibuf_instr <= imem_rsp_data;
         end

         case (state)
            S_IDLE:  state <= S_FETCH;
            S_FETCH: if (req_fire) state <= S_WAIT;
            S_WAIT: begin
               if (pc_jump_enable) begin
                  // Stale response either arrives now (dropped) or later.
                  state <= imem_rsp_valid ? S_FETCH : S_DRAIN;
               end else if (imem_rsp_valid) begin
                  state <= req_fire ? S_WAIT : S_FETCH;
               end
            end
            S_DRAIN: if (imem_rsp_valid) state <= S_FETCH;
            default: state <= S_IDLE;
         endcase
      end
   end

   // IF/ID register: flush beats stall, stall holds, otherwise load a source.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_valid    <= 1'b0;
         id_pc       <= '0;
         id_instr    <= NOP_INSTR;
         id_pc_plus4 <= FOUR;
      end else if (hazard_if_id_clear) begin
         id_valid    <= 1'b0;
         id_pc       <= '0;
         id_instr    <= NOP_INSTR;
         id_pc_plus4 <= FOUR;
      end else if (hazard_fe_enable) begin
         if (ibuf_valid) begin
            id_valid    <= 1'b1;
            id_pc       <= ibuf_pc;
            id_instr    <= ibuf_instr;
            id_pc_plus4 <= ibuf_pc + FOUR;
         end else if (rsp_direct) begin
            id_valid    <= 1'b1;
            id_pc       <= req_pc_q;
            id_instr    <= imem_rsp_data;
            id_pc_plus4 <= req_pc_q + FOUR;
         end else begin
            id_valid    <= 1'b0;
            id_pc       <= '0;
            id_instr    <= NOP_INSTR;
            id_pc_plus4 <= FOUR;
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small variable-latency memory model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fetch_unit;

   localparam logic [31:0] KEY = 32'hA5A5_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic        hazard_fe_enable;
   logic        hazard_if_id_clear;
   logic        pc_jump_enable;
   logic [31:0] pc_jump_addr;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic [31:0] id_pc_plus4;

   int n_cmp = 0;
   int n_bad = 0;

   // memory model state
   int          lat = 1;
   logic        mem_busy;
   int          mem_cnt;
   logic [31:0] mem_addr;
   logic [31:0] acc_addr;
   int          acc_cnt;

   fetch_unit dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .hazard_fe_enable   (hazard_fe_enable),
      .hazard_if_id_clear (hazard_if_id_clear),
      .pc_jump_enable     (pc_jump_enable),
      .pc_jump_addr       (pc_jump_addr),
      .imem_req_valid     (imem_req_valid),
      .imem_req_ready     (imem_req_ready),
      .imem_req_addr      (imem_req_addr),
      .imem_rsp_valid     (imem_rsp_valid),
      .imem_rsp_data      (imem_rsp_data),
      .id_valid           (id_valid),
      .id_pc              (id_pc),
      .id_instr           (id_instr),
      .id_pc_plus4        (id_pc_plus4)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory: responds lat cycles after acceptance with addr ^ KEY
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         imem_rsp_valid <= 1'b0;
         imem_rsp_data  <= '0;
         mem_busy       <= 1'b0;
         mem_cnt        <= 0;
         mem_addr       <= '0;
         acc_addr       <= '0;
         acc_cnt        <= 0;
      end else begin
         imem_rsp_valid <= 1'b0;
         if (mem_busy) begin
            if (mem_cnt == 1) begin
               imem_rsp_valid <= 1'b1;
               imem_rsp_data  <= mem_addr ^ KEY;
               mem_busy       <= 1'b0;
            end else begin
               mem_cnt <= mem_cnt - 1;
            end
         end
         if (imem_req_valid && imem_req_ready) begin
            acc_addr <= imem_req_addr;
            acc_cnt  <= acc_cnt + 1;
            if (lat == 1) begin
               imem_rsp_valid <= 1'b1;
               imem_rsp_data  <= imem_req_addr ^ KEY;
            end else begin
               mem_busy <= 1'b1;
               mem_cnt  <= lat - 1;
               mem_addr <= imem_req_addr;
            end
         end
      end
   end

   // driver: reset with default inputs, release on a falling edge
   task automatic do_reset();
      rst_n              = 1'b0;
      hazard_fe_enable   = 1'b1;
      hazard_if_id_clear = 1'b0;
      pc_jump_enable     = 1'b0;
      pc_jump_addr       = '0;
      imem_req_ready     = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n              = 1'b0;
      hazard_fe_enable   = 1'b1;
      hazard_if_id_clear = 1'b0;
      pc_jump_enable     = 1'b0;
      pc_jump_addr       = '0;
      imem_req_ready     = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL reset_id_valid got %h want %h", id_valid, 1'b0); end
      n_cmp++; if (id_pc !== 32'h0) begin n_bad++; $display("FAIL reset_id_pc got %h want %h", id_pc, 32'h0); end
      n_cmp++; if (id_instr !== NOP) begin n_bad++; $display("FAIL reset_id_instr got %h want %h", id_instr, NOP); end
      n_cmp++; if (id_pc_plus4 !== 32'h4) begin n_bad++; $display("FAIL reset_id_pc_plus4 got %h want %h", id_pc_plus4, 32'h4); end
      n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_req_valid got %h want %h", imem_req_valid, 1'b0); end
   endtask

   task automatic test_pipeline();
      logic [31:0] exp_pc;
      lat = 1;
      do_reset();
      @(negedge clk);  // after first edge: FETCH
      n_cmp++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL pipe_req0 got %h/%h want 1/00000000", imem_req_valid, imem_req_addr); end
      @(negedge clk);
      n_cmp++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h4}) begin n_bad++; $display("FAIL pipe_req4 got %h/%h want 1/00000004", imem_req_valid, imem_req_addr); end
      n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL pipe_early_id_valid got %h want 0", id_valid); end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         exp_pc = 32'(4 * k);
         n_cmp++; if (id_valid !== 1'b1) begin n_bad++; $display("FAIL pipe_id_valid k=%0d got %h want 1", k, id_valid); end
         n_cmp++; if (id_pc !== exp_pc) begin n_bad++; $display("FAIL pipe_id_pc k=%0d got %h want %h", k, id_pc, exp_pc); end
         n_cmp++; if (id_instr !== (exp_pc ^ KEY)) begin n_bad++; $display("FAIL pipe_id_instr k=%0d got %h want %h", k, id_instr, exp_pc ^ KEY); end
         n_cmp++; if (imem_req_addr !== exp_pc + 32'h8) begin n_bad++; $display("FAIL pipe_req_addr k=%0d got %h want %h", k, imem_req_addr, exp_pc + 32'h8); end
      end
   endtask

   task automatic test_stall();
      lat = 1;
      do_reset();
      repeat (5) @(negedge clk);
      n_cmp++; if (id_pc !== 32'h8) begin n_bad++; $display("FAIL stall_start id_pc got %h want %h", id_pc, 32'h8); end
      hazard_fe_enable = 1'b0;
      #1;
      n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL stall_no_b2b got %h want 0", imem_req_valid); end
      @(negedge clk);
      n_cmp++; if (id_pc !== 32'h8) begin n_bad++; $display("FAIL stall_hold1 id_pc got %h want %h", id_pc, 32'h8); end
      n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL stall_ibuf_block1 got %h want 0", imem_req_valid); end
      @(negedge clk);
      n_cmp++; if (id_pc !== 32'h8) begin n_bad++; $display("FAIL stall_hold2 id_pc got %h want %h", id_pc, 32'h8); end
      hazard_fe_enable = 1'b1;
      #1;
      n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL stall_ibuf_block2 got %h want 0", imem_req_valid); end
      @(negedge clk);
      n_cmp++; if ({id_valid, id_pc} !== {1'b1, 32'hC}) begin n_bad++; $display("FAIL stall_ibuf_out got %h/%h want 1/0000000c", id_valid, id_pc); end
      n_cmp++; if (id_instr !== 32'hA5A5_000C) begin n_bad++; $display("FAIL stall_ibuf_instr got %h want a5a5000c", id_instr); end
      n_cmp++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h10}) begin n_bad++; $display("FAIL stall_req16 got %h/%h want 1/00000010", imem_req_valid, imem_req_addr); end
   endtask

   task automatic test_redirect();
      lat = 3;
      do_reset();
      @(negedge clk);
      pc_jump_enable = 1'b1;
      pc_jump_addr   = 32'h12;  // low bits dropped
      #1;
      n_cmp++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h10}) begin n_bad++; $display("FAIL redir_fetch_req got %h/%h want 1/00000010", imem_req_valid, imem_req_addr); end
      @(negedge clk);
      pc_jump_addr = 32'h100;
      #1;
      n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL redir_wait_req got %h want 0", imem_req_valid); end
      @(negedge clk);
      pc_jump_enable = 1'b0;
      #1;
      n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL redir_drain_req got %h want 0", imem_req_valid); end
      @(negedge clk);
      n_cmp++; if ({imem_rsp_valid, imem_req_valid} !== 2'b10) begin n_bad++; $display("FAIL redir_drain_rsp got rsp=%h req=%h want rsp=1 req=0", imem_rsp_valid, imem_req_valid); end
      @(negedge clk);
      n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL redir_stale_dropped id_valid got %h want 0", id_valid); end
      n_cmp++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h100}) begin n_bad++; $display("FAIL redir_target_req got %h/%h want 1/00000100", imem_req_valid, imem_req_addr); end
      repeat (3) @(negedge clk);
      n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL redir_wait_id_valid got %h want 0", id_valid); end
      @(negedge clk);
      n_cmp++; if ({id_valid, id_pc} !== {1'b1, 32'h100}) begin n_bad++; $display("FAIL redir_id got %h/%h want 1/00000100", id_valid, id_pc); end
      n_cmp++; if (id_pc_plus4 !== 32'h104) begin n_bad++; $display("FAIL redir_pc_plus4 got %h want 00000104", id_pc_plus4); end
      n_cmp++; if (id_instr !== 32'hA5A5_0100) begin n_bad++; $display("FAIL redir_instr got %h want a5a50100", id_instr); end
   endtask

   task automatic test_flush_during_stall();
      lat = 1;
      do_reset();
      repeat (5) @(negedge clk);
      hazard_fe_enable = 1'b0;
      @(negedge clk);
      hazard_if_id_clear = 1'b1;
      @(negedge clk);
      n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL flush_id_valid got %h want 0", id_valid); end
      n_cmp++; if (id_instr !== NOP) begin n_bad++; $display("FAIL flush_id_instr got %h want %h", id_instr, NOP); end
      n_cmp++; if (id_pc !== 32'h0) begin n_bad++; $display("FAIL flush_id_pc got %h want 0", id_pc); end
      hazard_if_id_clear = 1'b0;
      hazard_fe_enable   = 1'b1;
      @(negedge clk);
      n_cmp++; if ({id_valid, id_pc} !== {1'b1, 32'hC}) begin n_bad++; $display("FAIL flush_ibuf_kept got %h/%h want 1/0000000c", id_valid, id_pc); end
      n_cmp++; if (id_instr !== 32'hA5A5_000C) begin n_bad++; $display("FAIL flush_ibuf_instr got %h want a5a5000c", id_instr); end
   endtask

   task automatic test_backpressure();
      lat = 1;
      do_reset();
      imem_req_ready = 1'b0;
      @(negedge clk);
      n_cmp++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL bp_req1 got %h/%h want 1/00000000", imem_req_valid, imem_req_addr); end
      @(negedge clk);
      n_cmp++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL bp_req2 got %h/%h want 1/00000000", imem_req_valid, imem_req_addr); end
      n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL bp_bubble got %h want 0", id_valid); end
      pc_jump_enable = 1'b1;
      pc_jump_addr   = 32'h200;
      #1;
      n_cmp++; if (imem_req_addr !== 32'h200) begin n_bad++; $display("FAIL bp_redir_addr got %h want 00000200", imem_req_addr); end
      @(negedge clk);
      pc_jump_enable = 1'b0;
      #1;
      n_cmp++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h200}) begin n_bad++; $display("FAIL bp_req3 got %h/%h want 1/00000200", imem_req_valid, imem_req_addr); end
      imem_req_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if ({acc_cnt, acc_addr} !== {32'd1, 32'h200}) begin n_bad++; $display("FAIL bp_accepted got cnt=%0d addr=%h want cnt=1 addr=00000200", acc_cnt, acc_addr); end
      @(negedge clk);
      n_cmp++; if ({id_valid, id_pc} !== {1'b1, 32'h200}) begin n_bad++; $display("FAIL bp_id got %h/%h want 1/00000200", id_valid, id_pc); end
   endtask

   task automatic test_wrap();
      lat = 1;
      do_reset();
      @(negedge clk);
      pc_jump_enable = 1'b1;
      pc_jump_addr   = 32'hFFFF_FFFC;
      #1;
      n_cmp++; if (imem_req_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_req got %h want fffffffc", imem_req_addr); end
      @(negedge clk);
      pc_jump_enable = 1'b0;
      #1;
      n_cmp++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL wrap_next_req got %h/%h want 1/00000000", imem_req_valid, imem_req_addr); end
      @(negedge clk);
      n_cmp++; if ({id_valid, id_pc} !== {1'b1, 32'hFFFF_FFFC}) begin n_bad++; $display("FAIL wrap_id got %h/%h want 1/fffffffc", id_valid, id_pc); end
      n_cmp++; if (id_pc_plus4 !== 32'h0) begin n_bad++; $display("FAIL wrap_pc_plus4 got %h want 00000000", id_pc_plus4); end
   endtask

   task automatic test_async_reset();
      lat = 3;
      do_reset();
      repeat (5) @(negedge clk);
      n_cmp++; if ({id_valid, id_pc} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL areset_pre got %h/%h want 1/00000000", id_valid, id_pc); end
      #2;
      rst_n = 1'b0;
      #1;  // still well before the next rising edge
      n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL areset_id_valid got %h want 0", id_valid); end
      n_cmp++; if (id_instr !== NOP) begin n_bad++; $display("FAIL areset_id_instr got %h want %h", id_instr, NOP); end
      n_cmp++; if (id_pc_plus4 !== 32'h4) begin n_bad++; $display("FAIL areset_pc_plus4 got %h want 4", id_pc_plus4); end
      n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL areset_req_valid got %h want 0", imem_req_valid); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL areset_first_req got %h/%h want 1/00000000", imem_req_valid, imem_req_addr); end
   endtask

   initial begin
      test_reset();
      test_pipeline();
      test_stall();
      test_redirect();
      test_flush_during_stall();
      test_backpressure();
      test_wrap();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage of the 5-stage RV32 pipeline, together with the IF/ID pipeline register. Holds the PC and issues word requests to instruction memory over a valid/ready request channel with a variable-latency response. Absorbs one response in a skid buffer while ID is stalled. Obeys the hazard unit's hazard_fe_enable (stall) and hazard_if_id_clear (flush), plus the EX-stage redirect pc_jump_enable/pc_jump_addr.

Parameters:
XLEN, 32, PC/address width
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
hazard_fe_enable  in  1  0 = stall: IF/ID holds
hazard_if_id_clear  in  1  1 = load bubble into IF/ID
pc_jump_enable  in  1  redirect fetch to pc_jump_addr
pc_jump_addr  in  XLEN  redirect target; bits[1:0] forced to 0
imem_req_valid  out  1  request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  word address requested
imem_rsp_valid  in  1  response valid (in order, never back-pressured)
imem_rsp_data  in  32  instruction word
id_valid  out  1  IF/ID holds a real instruction
id_pc  out  XLEN  PC of id_instr
id_instr  out  32  instruction to decode
id_pc_plus4  out  XLEN  id_pc+4, mod 2^XLEN

Behaviour:
- Reset (async, immediate): state=IDLE; pc_q=RESET_PC; ibuf empty; id_valid=0, id_pc=0, id_instr=NOP_INSTR, id_pc_plus4=4; imem_req_valid=0.
- The memory resets on the same rst_n, so no response survives reset.
- States:
  - IDLE: goes to FETCH on the first clock after reset release.
  - FETCH: waiting to issue.
  - WAIT: one request outstanding.
  - DRAIN: outstanding request was made stale by a redirect.
- At most one request outstanding.
- imem_req_valid = (FETCH && !ibuf_valid) || (WAIT && imem_rsp_valid && ifid_load && !ibuf_valid && !pc_jump_enable). The second term is the back-to-back issue that gives 1 instr/cycle with 1-cycle memory.
- imem_req_addr = pc_jump_addr when pc_jump_enable, else pc_q.
- Address may change before acceptance. The memory samples only on valid&&ready.
- On handshake: req_pc_q <= imem_req_addr; pc_q <= imem_req_addr+4 (wraps at 2^XLEN); next state WAIT.
- ifid_load = hazard_fe_enable && !hazard_if_id_clear.
- IF/ID update, priority order:
  1. hazard_if_id_clear: bubble (id_valid=0, id_instr=NOP_INSTR, id_pc=0). Overrides stall.
  2. !hazard_fe_enable: hold all id_* outputs.
  3. ifid_load with a source:
     - ibuf full: take ibuf, empty it.
     - Else WAIT && imem_rsp_valid && !pc_jump_enable: take {req_pc_q, imem_rsp_data}.
     - Else: load bubble.
- WAIT response handling:
  - Response arriving with !ifid_load and no redirect goes into ibuf; state becomes FETCH.
  - Response consumed directly goes to FETCH, or stays WAIT if a back-to-back request was accepted.
- Redirect (pc_jump_enable, any state except IDLE):
  - pc_q <= target; ibuf cleared.
  - In WAIT with no response this cycle: go to DRAIN.
  - In WAIT with a response this cycle: response discarded; go to FETCH.
  - In FETCH: the target is requested this cycle.
- DRAIN: next imem_rsp_valid is discarded; go to FETCH. imem_req_valid=0. A redirect in DRAIN updates pc_q only.
- Redirect and flush in the same cycle: both apply. Redirect and stall in the same cycle: redirect still updates pc_q and ibuf; IF/ID holds.
- ibuf full blocks new requests. Flush alone does not clear ibuf.
- id_pc_plus4 is registered alongside id_pc: 32'hFFFF_FFFC gives 0.

Test Plan:
- 1-cycle memory (ready=1, rsp next cycle, data=addr^32'hA5A5_0000), RESET_PC=0 -> requests 0,4,8,... on consecutive cycles; id_pc=0 valid 3 cycles after reset release, then 4,8 on consecutive cycles.
- Stall: hold hazard_fe_enable=0 for 2 cycles while id_pc=8 -> id_pc stays 8; response for 12 goes to ibuf; no request for 16 while ibuf full; after release id_pc=12, then request 16 issued.
- Redirect with 3-cycle memory: pc_jump_enable with addr 0x100 one cycle after request 0x10 accepted -> 0x10 response discarded (DRAIN); next request addr 0x100; id_valid=0 until 0x100 loaded with id_pc_plus4=0x104.
- Flush during stall: hazard_if_id_clear=1, hazard_fe_enable=0 -> next cycle id_valid=0, id_instr=0x00000013; ibuf contents delivered afterward.
- Back-pressure: imem_req_ready=0 for 3 cycles -> imem_req_valid held 1, addr stable, ID gets bubbles; redirect to 0x200 mid-stall -> addr becomes 0x200; accepted address is 0x200.
- Async reset asserted in WAIT -> all outputs at reset values without a clock edge; after release, first request addr = RESET_PC.
